// File: rtl/stream_max_tracker_pkg.sv
// stream_max_tracker_pkg: shared mode constants, FSM encoding and default sizes.
package stream_max_tracker_pkg;
  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_IDX_W = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_HOLD} state_t;
endpackage

// File: rtl/stream_max_tracker_cmp.sv
// ext_cmp: strict win test of a against b, greater for max mode, less for min mode.
module ext_cmp
  import stream_max_tracker_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             a_wins
);
  logic gt, lt;
  assign gt = SIGNED ? ($signed(a) > $signed(b)) : (a > b);
  assign lt = SIGNED ? ($signed(a) < $signed(b)) : (a < b);
  assign a_wins = (mode == MODE_MIN) ? lt : gt;
endmodule

// File: rtl/stream_max_tracker.sv
// stream_max_tracker: per-frame max/min finder reporting value, index and element count.
module stream_max_tracker
  import stream_max_tracker_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int IDX_W  = DEF_IDX_W,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [IDX_W-1:0] out_index,
  output logic [IDX_W:0]   out_count,
  output logic             out_overflow
);
  localparam logic [IDX_W:0] FULL = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0] ONE  = (IDX_W+1)'(1);
  state_t state_q, state_d;
  logic mode_q, mode_d, ovf_q, ovf_d, out_ovf_q, out_ovf_d;
  logic [WIDTH-1:0] best_q, best_d, out_value_q, out_value_d;
  logic [IDX_W-1:0] idx_q, idx_d, out_index_q, out_index_d, cur_idx;
  logic [IDX_W:0] cnt_q, cnt_d, out_count_q, out_count_d;
  logic acc, win, full;
  ext_cmp #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp (
    .a(in_data), .b(best_q), .mode(mode_q), .a_wins(win)
  );
  assign in_ready = !rst && state_q != ST_HOLD;
  assign acc = in_valid && in_ready;
  assign full = cnt_q == FULL;
  // Elements past the exact range report the last representable index.
  assign cur_idx = full ? '1 : cnt_q[IDX_W-1:0];
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    best_d = best_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    case (state_q)
      ST_IDLE: if (acc) begin
        mode_d = in_mode;
        best_d = in_data;
        idx_d = '0;
        cnt_d = ONE;
        ovf_d = 1'b0;
        state_d = in_last ? ST_HOLD : ST_ACCUM;
      end
      ST_ACCUM: if (acc) begin
        best_d = win ? in_data : best_q;
        idx_d = win ? cur_idx : idx_q;
        cnt_d = full ? cnt_q : cnt_q + ONE;
        ovf_d = ovf_q | full;
        state_d = in_last ? ST_HOLD : ST_ACCUM;
      end
      ST_HOLD: state_d = out_ready ? ST_IDLE : ST_HOLD;
      default: state_d = ST_IDLE;
    endcase
  end
  // Results are captured at the closing element so they stay stable through HOLD.
  assign out_value_d = (acc && in_last) ? best_d : out_value_q;
  assign out_index_d = (acc && in_last) ? idx_d : out_index_q;
  assign out_count_d = (acc && in_last) ? cnt_d : out_count_q;
  assign out_ovf_d = (acc && in_last) ? ovf_d : out_ovf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q <= MODE_MAX;
      best_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      out_value_q <= '0;
      out_index_q <= '0;
      out_count_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      best_q <= best_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      out_value_q <= out_value_d;
      out_index_q <= out_index_d;
      out_count_q <= out_count_d;
      out_ovf_q <= out_ovf_d;
    end
  end
  assign out_valid = state_q == ST_HOLD;
  assign out_value = out_value_q;
  assign out_index = out_index_q;
  assign out_count = out_count_q;
  assign out_overflow = out_ovf_q;
endmodule

// File: tb/tb_stream_max_tracker.sv
// tb_stream_max_tracker: directed frames against unsigned, signed and narrow-index instances.
module tb_stream_max_tracker;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic rdy0, rdy1, rdy2, ov0, ov1, ov2, ovf0, ovf1, ovf2;
  logic [7:0] val0, val1, val2, idx0, idx1;
  logic [1:0] idx2;
  logic [8:0] cnt0, cnt1;
  logic [2:0] cnt2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  stream_max_tracker u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_last(in_last), .in_mode(in_mode), .out_valid(ov0), .out_ready(out_ready),
    .out_value(val0), .out_index(idx0), .out_count(cnt0), .out_overflow(ovf0)
  );
  stream_max_tracker #(.SIGNED(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_last(in_last), .in_mode(in_mode), .out_valid(ov1), .out_ready(out_ready),
    .out_value(val1), .out_index(idx1), .out_count(cnt1), .out_overflow(ovf1)
  );
  stream_max_tracker #(.IDX_W(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .in_last(in_last), .in_mode(in_mode), .out_valid(ov2), .out_ready(out_ready),
    .out_value(val2), .out_index(idx2), .out_count(cnt2), .out_overflow(ovf2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input logic [7:0] d, input logic l, input logic m);
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    in_mode = m;
    while (!rdy0 && n < 20) begin
      cyc(1);
      n++;
    end
    if (n >= 20) chk("push_timeout", 0, 1);
    cyc(1);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic pop;
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    cyc(2);
    chk("rst_ready", {rdy0, rdy1, rdy2}, 3'b000);
    chk("rst_valid", ov0, 0);
    chk("rst_value", val0, 0);
    chk("rst_index", idx0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_ovf", ovf0, 0);
    rst = 1'b0;
    cyc(1);
    chk("idle_ready", {rdy0, rdy1, rdy2}, 3'b111);
    pop;
    chk("idle_oready", {ov0, ov1, ov2}, 3'b000);
    push(8'd10, 0, 0); push(8'd20, 0, 0); push(8'd20, 0, 0);
    chk("a_pre_valid", ov0, 0);
    push(8'd5, 1, 0);
    chk("a_valid", ov0, 1);
    chk("a_value", val0, 20);
    chk("a_index", idx0, 1);
    chk("a_count", cnt0, 4);
    chk("a_ovf", ovf0, 0);
    chk("a_narrow", {idx2, cnt2, ovf2}, {2'd1, 3'd4, 1'b0});
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("bp_valid", ov0, 1);
      chk("bp_value", {val0, idx0}, {8'd20, 8'd1});
      chk("bp_ready", rdy0, 0);
    end
    pop;
    chk("pop_ready", rdy0, 1);
    chk("pop_valid", ov0, 0);
    push(8'h05, 0, 1); push(8'hF0, 0, 1); push(8'h7F, 1, 1);
    chk("b_s_value", val1, 8'hF0);
    chk("b_s_index", idx1, 1);
    chk("b_s_count", {ovf1, cnt1}, {1'b0, 9'd3});
    chk("b_u_value", val0, 8'h05);
    chk("b_u_index", idx0, 0);
    chk("b_u_count", cnt0, 3);
    pop;
    push(8'd30, 1, 1);
    chk("c_valid", ov0, 1);
    chk("c_value", val0, 30);
    chk("c_index", idx0, 0);
    chk("c_count", cnt0, 1);
    pop;
    push(8'd1, 0, 0); push(8'd2, 0, 0); push(8'd3, 0, 0); push(8'd4, 0, 0); push(8'd9, 1, 0);
    chk("d_n_value", val2, 9);
    chk("d_n_index", idx2, 3);
    chk("d_n_count", cnt2, 4);
    chk("d_n_ovf", ovf2, 1);
    chk("d_w_result", {idx0, cnt0, ovf0}, {8'd4, 9'd5, 1'b0});
    chk("d_valid_all", {ov0, ov1, ov2}, 3'b111);
    pop;
    push(8'd50, 0, 0); push(8'd60, 0, 0); push(8'd70, 0, 0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("abort_valid", ov0, 0);
    chk("abort_outs", {val0, cnt0, ovf0}, 18'd0);
    cyc(1);
    chk("abort_still", ov0, 0);
    push(8'd7, 0, 0); push(8'd2, 1, 1);
    chk("e_valid", ov0, 1);
    chk("e_value", val0, 7);
    chk("e_index", idx0, 0);
    chk("e_count", cnt0, 2);
    pop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
